// File: rtl/div_mod_scheduler.sv
// div_mod_scheduler
//   Shared unsigned divider front end. It arbitrates between two requesters,
//   then runs a 32/16 non-restoring division that retires STEPS quotient bits
//   per cycle. The quotient or remainder comes back tagged on a valid/ready
//   response port.
//
//   Optional feature macro: DIVSCHED_RR_EN
//     defined   -> round-robin arbitration when both ports are valid
//     undefined -> fixed priority, port 0 wins ties
//
//   Ports
//     clk, reset                 clock, synchronous active-high reset
//     reqN_valid / reqN_ready    request handshake per port (N = 0, 1)
//     reqN_mode                  1 = quotient, 0 = remainder
//     reqN_dividend / _divisor   32-bit / 16-bit unsigned operands
//     resp_valid / resp_ready    response handshake
//     resp_id                    port that issued the request
//     resp_result                quotient, or zero-extended remainder
//     resp_dbz                   divisor was zero
module div_mod_scheduler #(
    parameter int STEPS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_mode,
    input  logic [31:0] req0_dividend,
    input  logic [15:0] req0_divisor,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_mode,
    input  logic [31:0] req1_dividend,
    input  logic [15:0] req1_divisor,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_result,
    output logic        resp_dbz
);

    localparam int         CYCLES   = 32 / STEPS;
    localparam logic [5:0] LAST_CNT = 6'(CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state, state_nxt;

    logic               last_grant;
    logic [5:0]         cnt_r;
    logic               mode_r;
    logic [31:0]        dvd_r;
    logic [15:0]        divisor_r;
    logic signed [16:0] rem_r;
    logic [31:0]        quo_r;

    logic               grant1;
    logic               accept;
    logic               sel_mode;
    logic [31:0]        sel_dividend;
    logic [15:0]        sel_divisor;

    logic signed [16:0] rem_calc;
    logic [31:0]        dvd_calc;
    logic [31:0]        quo_calc;

    // One non-restoring step. The shifted remainder spans [-2d, 2d) and needs
    // 18 bits; after the add/subtract it is back in [-d, d) and fits 17.
    function automatic logic signed [16:0] nr_step(input logic signed [16:0] rem,
                                                   input logic               bit_in,
                                                   input logic [15:0]        dvs);
        logic signed [17:0] shifted;
        logic signed [17:0] dvs_ext;
        logic signed [17:0] nxt;
        shifted = {rem, bit_in};
        dvs_ext = $signed({2'b00, dvs});
        nxt     = rem[16] ? shifted + dvs_ext : shifted - dvs_ext;
        return nxt[16:0];
    endfunction

    // A negative final partial remainder is restored by one add.
    function automatic logic [15:0] nr_fix(input logic signed [16:0] rem,
                                           input logic [15:0]        dvs);
        logic signed [16:0] fixed;
        fixed = rem[16] ? rem + $signed({1'b0, dvs}) : rem;
        return fixed[15:0];
    endfunction

    // Arbitration and operand selection
    always_comb begin
`ifdef DIVSCHED_RR_EN
        grant1 = req1_valid && (!req0_valid || !last_grant);
`else
        grant1 = req1_valid && !req0_valid;
`endif
        accept       = (state == IDLE) && (req0_valid || req1_valid);
        sel_mode     = grant1 ? req1_mode     : req0_mode;
        sel_dividend = grant1 ? req1_dividend : req0_dividend;
        sel_divisor  = grant1 ? req1_divisor  : req0_divisor;
    end

    // STEPS unrolled steps per CALC cycle, dividend consumed MSB first
    always_comb begin
        rem_calc = rem_r;
        dvd_calc = dvd_r;
        quo_calc = quo_r;
        for (int i = 0; i < STEPS; i++) begin
            rem_calc = nr_step(rem_calc, dvd_calc[31], divisor_r);
            dvd_calc = {dvd_calc[30:0], 1'b0};
            quo_calc = {quo_calc[30:0], ~rem_calc[16]};
        end
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    req0_ready = !grant1;
                    req1_ready = grant1;
                    state_nxt  = (sel_divisor == 16'd0) ? DONE : CALC;
                end
            end
            CALC:    if (cnt_r == LAST_CNT) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign resp_valid = (state == DONE);

    // Control and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            cnt_r       <= '0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_dbz    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        last_grant <= grant1;
                        resp_id    <= grant1;
                        cnt_r      <= '0;
                        resp_dbz   <= (sel_divisor == 16'd0);
                        if (sel_divisor == 16'd0)
                            resp_result <= sel_mode ? 32'hFFFF_FFFF : {16'b0, sel_dividend[15:0]};
                    end
                end
                CALC: cnt_r <= cnt_r + 6'd1;
                FIX:  resp_result <= mode_r ? quo_r : {16'b0, nr_fix(rem_r, divisor_r)};
                default: ;
            endcase
        end
    end

    // Datapath registers, loaded on accept and advanced during CALC
    always_ff @(posedge clk) begin
        if (accept) begin
            mode_r    <= sel_mode;
            dvd_r     <= sel_dividend;
            divisor_r <= sel_divisor;
            rem_r     <= '0;
            quo_r     <= '0;
        end else if (state == CALC) begin
            rem_r <= rem_calc;
            dvd_r <= dvd_calc;
            quo_r <= quo_calc;
        end
    end

endmodule

// File: tb/tb_div_mod_scheduler.sv
module tb_div_mod_scheduler;

    localparam int STEPS = 4;
    localparam int LAT   = 32 / STEPS + 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req0_mode;
    logic [31:0] req0_dividend;
    logic [15:0] req0_divisor;
    logic        req1_valid, req1_ready, req1_mode;
    logic [31:0] req1_dividend;
    logic [15:0] req1_divisor;
    logic        resp_valid, resp_ready, resp_id, resp_dbz;
    logic [31:0] resp_result;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    div_mod_scheduler #(.STEPS(STEPS)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
        .req0_dividend(req0_dividend), .req0_divisor(req0_divisor),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
        .req1_dividend(req1_dividend), .req1_divisor(req1_divisor),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_dbz(resp_dbz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: one outstanding request, result by plain / and %,
    // response due a fixed number of cycles after the accept.
    logic        m_busy = 1'b0;
    logic        m_lg   = 1'b1;
    int          m_due;
    logic        m_id, m_dbz, m_exp_valid, m_any, m_w;
    logic [31:0] m_res, m_dvd, m_dvs;
    logic        m_mode;

    always @(negedge clk) begin
        if (reset) begin
            m_busy = 1'b0;
            m_lg   = 1'b1;
        end else begin
            m_exp_valid = m_busy && (cyc >= m_due);
            m_any       = req0_valid || req1_valid;
            if (req0_valid && req1_valid) begin
`ifdef DIVSCHED_RR_EN
                m_w = !m_lg;
`else
                m_w = 1'b0;
`endif
            end else begin
                m_w = req1_valid;
            end
            check("ready0", req0_ready, !m_busy && m_any && !m_w);
            check("ready1", req1_ready, !m_busy && m_any && m_w);
            check("resp_valid", resp_valid, m_exp_valid);
            if (m_exp_valid) begin
                check("resp_id", resp_id, m_id);
                check("resp_result", resp_result, m_res);
                check("resp_dbz", resp_dbz, m_dbz);
                if (resp_ready) m_busy = 1'b0;
            end else if (!m_busy && m_any) begin
                m_dvd  = m_w ? req1_dividend : req0_dividend;
                m_dvs  = {16'b0, m_w ? req1_divisor : req0_divisor};
                m_mode = m_w ? req1_mode : req0_mode;
                m_dbz  = (m_dvs == 0);
                if (m_dbz) m_res = m_mode ? 32'hFFFF_FFFF : {16'b0, m_dvd[15:0]};
                else       m_res = m_mode ? m_dvd / m_dvs : m_dvd % m_dvs;
                m_id   = m_w;
                m_lg   = m_w;
                m_busy = 1'b1;
                m_due  = cyc + (m_dbz ? 1 : LAT);
            end
        end
    end

    task automatic issue(input logic port, input logic mode, input logic [31:0] dvd,
                         input logic [15:0] dvs, output int acc);
        logic got;
        got = 1'b0;
        acc = -1;
        @(posedge clk); #1;
        if (port) begin
            req1_valid = 1; req1_mode = mode; req1_dividend = dvd; req1_divisor = dvs;
        end else begin
            req0_valid = 1; req0_mode = mode; req0_dividend = dvd; req0_divisor = dvs;
        end
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if ((port ? req1_ready : req0_ready) === 1'b1) begin
                got = 1'b1;
                acc = cyc;
            end else begin
                @(posedge clk);
            end
        end
        if (got) @(posedge clk);
        #1;
        if (port) req1_valid = 0; else req0_valid = 0;
        check("accept_seen", got, 1'b1);
    endtask

    task automatic wait_resp(output int rc, output logic [31:0] res,
                             output logic id, output logic dbz);
        logic got;
        got = 1'b0;
        rc  = -1;
        res = '0; id = 0; dbz = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                got = 1'b1;
                rc  = cyc;
                res = resp_result;
                id  = resp_id;
                dbz = resp_dbz;
            end
        end
        check("resp_seen", got, 1'b1);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
    endtask

    int          acc, rc, rcyc, vcnt;
    logic [31:0] res;
    logic        id, dbz, got;
    logic        ids[4];

    initial begin
        reset = 1; resp_ready = 1;
        req0_valid = 0; req0_mode = 0; req0_dividend = 0; req0_divisor = 0;
        req1_valid = 0; req1_mode = 0; req1_dividend = 0; req1_divisor = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("rst_valid", resp_valid, 0);
        check("rst_id", resp_id, 0);
        check("rst_result", resp_result, 0);
        check("rst_dbz", resp_dbz, 0);
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);

        issue(0, 1, 100, 7, acc);
        wait_resp(rc, res, id, dbz);
        check("q100_7", res, 14);
        check("q100_7_id", id, 0);
        check("q100_7_lat", rc - acc, 10);
        issue(0, 0, 100, 7, acc);
        wait_resp(rc, res, id, dbz);
        check("r100_7", res, 2);

        issue(1, 1, 32'hFFFF_FFFF, 16'h0001, acc);
        wait_resp(rc, res, id, dbz);
        check("qmax_1", res, 32'hFFFF_FFFF);
        check("qmax_1_id", id, 1);
        issue(1, 0, 32'hFFFF_FFFF, 16'hFFFF, acc);
        wait_resp(rc, res, id, dbz);
        check("rmax_ffff", res, 0);
        issue(1, 1, 32'hFFFF_FFFF, 16'hFFFF, acc);
        wait_resp(rc, res, id, dbz);
        check("qmax_ffff", res, 32'h0001_0001);

        issue(0, 0, 32'h0000_1234, 16'h0000, acc);
        wait_resp(rc, res, id, dbz);
        check("dbz_result", res, 32'h0000_1234);
        check("dbz_flag", dbz, 1);
        check("dbz_lat", rc - acc, 1);
        issue(0, 1, 32'h0000_1234, 16'h0000, acc);
        wait_resp(rc, res, id, dbz);
        check("dbz_q", res, 32'hFFFF_FFFF);

        // Both ports held valid across four operations
        pulse_reset();
        @(posedge clk); #1;
        req0_valid = 1; req0_mode = 1; req0_dividend = 1000; req0_divisor = 10;
        req1_valid = 1; req1_mode = 0; req1_dividend = 999;  req1_divisor = 10;
        for (int k = 0; k < 4; k++) begin
            wait_resp(rc, res, id, dbz);
            ids[k] = id;
            check("both_result", res, id ? 32'd9 : 32'd100);
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        repeat (15) @(posedge clk);
`ifdef DIVSCHED_RR_EN
        check("rr_id0", ids[0], 0);
        check("rr_id1", ids[1], 1);
        check("rr_id2", ids[2], 0);
        check("rr_id3", ids[3], 1);
`else
        check("fp_id0", ids[0], 0);
        check("fp_id1", ids[1], 0);
        check("fp_id2", ids[2], 0);
        check("fp_id3", ids[3], 0);
`endif

        // Backpressure: response held for 20 cycles with port 1 waiting
        resp_ready = 0;
        issue(0, 1, 50, 5, acc);
        wait_resp(rc, res, id, dbz);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                req1_valid = 1; req1_mode = 0; req1_dividend = 60; req1_divisor = 7;
            end
            @(negedge clk);
            check("bp_valid", resp_valid, 1);
            check("bp_result", resp_result, 10);
            check("bp_id", resp_id, 0);
            check("bp_ready0", req0_ready, 0);
            check("bp_ready1", req1_ready, 0);
        end
        @(posedge clk); #1 resp_ready = 1;
        @(negedge clk);
        rcyc = cyc;
        check("hs_ready1", req1_ready, 0);
        @(negedge clk);
        check("next_accept", req1_ready, 1);
        check("accept_gap", cyc - rcyc, 1);
        @(posedge clk); #1 req1_valid = 0;
        wait_resp(rc, res, id, dbz);
        check("bp_next_result", res, 4);
        check("bp_next_id", id, 1);

        // Reset during CALC aborts the request
        issue(1, 1, 1000, 3, acc);
        repeat (3) @(posedge clk);
        #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        check("abort_valid", resp_valid, 0);
        check("abort_id", resp_id, 0);
        check("abort_result", resp_result, 0);
        check("abort_dbz", resp_dbz, 0);
        vcnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) vcnt++;
        end
        check("abort_no_resp", vcnt, 0);
        issue(0, 1, 50000, 3, acc);
        wait_resp(rc, res, id, dbz);
        check("q50000_3", res, 16666);
        check("q50000_3_lat", rc - acc, 10);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_mod_scheduler.md
# div_mod_scheduler

Shared-divider front end for the divider/modulo datapath. It arbitrates between two requesters, computes quotient or remainder of a 32-bit dividend by a 16-bit divisor, and returns a tagged result through a valid/ready response port. The block owns a multi-cycle non-restoring engine that retires STEPS quotient bits per cycle. It sits between the two client pipelines and the result bus and replaces per-client dividers.

## Interface
- STEPS, 4, quotient bits retired per CALC cycle; legal values are 1, 2, 4 and 8.
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  request present on port 0 / 1
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_mode / req1_mode  in  1  1 selects quotient, 0 selects remainder
- req0_dividend / req1_dividend  in  32  dividend, unsigned
- req0_divisor / req1_divisor  in  16  divisor, unsigned
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts the response
- resp_id  out  1  port that issued the request
- resp_result  out  32  quotient, or remainder zero-extended to 32 bits
- resp_dbz  out  1  divisor was zero

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - If any reqN_valid, grant one port and assert that port's reqN_ready combinationally for one cycle.
  - Capture mode, dividend, divisor and id.
  - Clear the 17-bit signed partial remainder and the step counter.
  - Next state: CALC; if divisor == 0, DONE.
- CALC: each cycle performs STEPS non-restoring steps, MSB first.
  - Shift the partial remainder left by one and bring in the next dividend bit.
  - Subtract the divisor if the remainder is non-negative; otherwise add it.
  - Quotient bit = NOT new sign.
  - After 32/STEPS cycles, go to FIX.
- FIX:
  - If the remainder is negative, add the divisor.
  - Load resp_result with quotient (mode 1) or {16'b0, remainder[15:0]} (mode 0).
  - Next state: DONE.
- Divide by zero: resp_result = 32'hFFFFFFFF in mode 1 and {16'b0, dividend[15:0]} in mode 0; resp_dbz = 1.
- DONE:
  - resp_valid = 1; resp_id, resp_result and resp_dbz are held stable.
  - When resp_valid && resp_ready, go to IDLE.
  - No request is accepted in DONE, CALC or FIX; reqN_ready = 0 in those states.
- Arbitration:
  - Only one requester valid: that port wins.
  - Both valid: the winner is given under Configuration.
  - last_grant updates on every accept.
- Results equal dividend / divisor and dividend % divisor exactly, for the full unsigned range.

## Timing
- Reset values: all ready 0, resp_valid 0, resp_id 0, resp_result 0, resp_dbz 0, state IDLE, last_grant 1.
- Reset asserted in any state aborts the operation on the next edge; no response is issued for it.
- Accept cycle T is the cycle reqN_valid && reqN_ready are both high.
  - CALC occupies T+1 .. T+32/STEPS.
  - FIX occupies T+32/STEPS+1.
  - resp_valid first rises in cycle T+32/STEPS+2, which is T+10 for STEPS=4.
- Divide by zero: resp_valid rises in T+1.
- The response handshake completes in cycle R. The earliest next accept is cycle R+1, so issue interval = latency+1 with no backpressure.
- Inputs are sampled only in the accept cycle. Requesters must hold valid and operands until they see ready.
- resp_ready low stalls DONE indefinitely without changing any output.

## Configuration
- DIVSCHED_RR_EN defined: round-robin arbitration. When both ports are valid in IDLE, the port != last_grant wins. After reset port 0 wins first, then the ports alternate.
- DIVSCHED_RR_EN undefined: fixed priority. Port 0 always wins a tie; last_grant is still kept but ignored.

## Test plan
- Port 0 sends 100 / 7, mode 1, STEPS=4 -> resp_result 14, resp_id 0, resp_valid rises 10 cycles after accept. The same operands with mode 0 -> 2.
- Port 1 sends 32'hFFFFFFFF / 16'h0001, mode 1 -> 32'hFFFFFFFF. Then 32'hFFFFFFFF / 16'hFFFF, mode 0 -> 0.
- Port 0 sends 32'h00001234 / 0, mode 0 -> resp_result 32'h00001234 and resp_dbz 1, one cycle after accept.
- Both ports held valid for four operations:
  - With DIVSCHED_RR_EN: resp_id sequence 0,1,0,1.
  - Without it: port 0 is served repeatedly while port 1 starves.
- resp_ready held low for 20 cycles after resp_valid -> result and id stay stable, both ready outputs stay 0, and the next accept occurs the cycle after resp_ready rises.
- Reset pulsed for one cycle during CALC -> all outputs return to reset values, no response for the aborted request, and a fresh 50000 / 3 request then returns 16666.
